// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package core_fetch_pkg;

  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT   = 32'h0000_0013;
  localparam logic        JUMP_ENABLE        = 1'b1;
  localparam logic        HOLD_ENABLE        = 1'b1;

  // A request is either absent or outstanding; one flop carries the whole FSM.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  // One fetched instruction together with the PC it came from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_fetch_if.sv
// rtl/core_fetch_if.sv - instruction bus between fetch stage and memory
interface core_fetch_if;

  logic        ibus_req_out;
  logic [31:0] ibus_addr_out;
  logic        ibus_ack_in;
  logic [31:0] ibus_data_in;

  modport master (
    output ibus_req_out,
    output ibus_addr_out,
    input  ibus_ack_in,
    input  ibus_data_in
  );

  modport slave (
    input  ibus_req_out,
    input  ibus_addr_out,
    output ibus_ack_in,
    output ibus_data_in
  );

endinterface

// File: rtl/core_fetch_skid.sv
// rtl/core_fetch_skid.sv - one-entry {addr, inst} holding register with load/drain/flush
module core_fetch_skid
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         drain,
  input  logic         flush,
  output logic         full,
  output fetch_entry_t entry
);

  // Flush beats load beats drain; contents are kept when emptied so the
  // owner can still present the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      entry.addr <= RESET_ADDR;
      entry.inst <= NOP_INST;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= load_entry;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/core_fetch.sv
// rtl/core_fetch.sv - instruction-fetch stage: PC, single-outstanding ibus, IF/ID register
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_in,
  input  logic [31:0]       jump_addr_in,
  input  logic              hold_flag_in,
  core_fetch_if.master      bus,
  output logic              inst_valid_out,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_addr_out
);

  fetch_state_t state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;

  logic         jump, hold, complete, take, issue;
  logic [31:0]  target;

  logic         skid_full, skid_load, skid_full_after;
  fetch_entry_t skid_entry;
  logic         ifid_full, ifid_load;
  fetch_entry_t ifid_entry, ifid_load_entry, bus_entry;

  assign jump     = (jump_flag_in == JUMP_ENABLE);
  assign hold     = (hold_flag_in == HOLD_ENABLE);
  assign target   = word_align(jump_addr_in);
  assign complete = (state_q == S_WAIT) && bus.ibus_ack_in;
  // A completion coincident with a jump belongs to the old path and is dropped.
  assign take     = complete && !kill_q && !jump;

  assign bus_entry.addr = addr_q;
  assign bus_entry.inst = bus.ibus_data_in;

  // The skid catches a returning instruction that the IF/ID register cannot take.
  assign skid_load       = take && (hold || skid_full);
  assign skid_full_after = !jump && (skid_load || (skid_full && hold));

  // IF/ID drains the skid first so program order is preserved.
  assign ifid_load       = !jump && !hold && (skid_full || take);
  assign ifid_load_entry = skid_full ? skid_entry : bus_entry;

  core_fetch_skid #(
    .RESET_ADDR (RESET_ADDR),
    .NOP_INST   (NOP_INST)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .load_entry (bus_entry),
    .drain      (!hold),
    .flush      (jump),
    .full       (skid_full),
    .entry      (skid_entry)
  );

  core_fetch_skid #(
    .RESET_ADDR (RESET_ADDR),
    .NOP_INST   (NOP_INST)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .load_entry (ifid_load_entry),
    .drain      (!hold),
    .flush      (jump),
    .full       (ifid_full),
    .entry      (ifid_entry)
  );

  // State register: bus request state, kill marker, fetch PC and request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: redirect handling, then issue whenever the bus and skid allow it.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    if (jump) begin
      if ((state_q == S_WAIT) && !complete) begin
        // The request cannot be withdrawn; mark it so its data is thrown away.
        kill_d = 1'b1;
        pc_d   = target;
      end else begin
        state_d = S_WAIT;
        kill_d  = 1'b0;
        addr_d  = target;
        pc_d    = target + 32'd4;
      end
    end else begin
      if (complete) begin
        kill_d = 1'b0;
      end
      issue = !skid_full_after && ((state_q == S_IDLE) || complete);
      if (issue) begin
        state_d = S_WAIT;
        addr_d  = pc_q;
        pc_d    = pc_q + 32'd4;
      end else if (complete) begin
        state_d = S_IDLE;
      end
    end
  end

  // Outputs: bus driven straight from flops, NOP substituted for an empty IF/ID.
  always_comb begin
    bus.ibus_req_out  = (state_q == S_WAIT);
    bus.ibus_addr_out = addr_q;
    inst_valid_out    = ifid_full;
    inst_out          = ifid_full ? ifid_entry.inst : NOP_INST;
    inst_addr_out     = ifid_entry.addr;
  end

endmodule

// File: tb/tb_core_fetch.sv
// tb/tb_core_fetch.sv - directed self-checking bench for core_fetch
module tb_core_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_in = 1'b0;
  logic [31:0] jump_addr_in = 32'h0;
  logic        hold_flag_in = 1'b0;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  core_fetch_if bus ();

  core_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .hold_flag_in   (hold_flag_in),
    .bus            (bus),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .inst_addr_out  (inst_addr_out)
  );

  always #5 clk = ~clk;

  // Memory model: data echoes the address, ack after ack_delay waiting edges.
  assign bus.ibus_ack_in  = bus.ibus_req_out && (wait_cnt >= ack_delay);
  assign bus.ibus_data_in = bus.ibus_addr_out;

  // Count edges the current request has been waiting.
  always_ff @(posedge clk) begin
    if (!bus.ibus_req_out || bus.ibus_ack_in) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag_in = 1'b0;
    hold_flag_in = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values and zero-wait streaming
    ack_delay = 0;
    do_reset();
    check("rst_req",   {31'b0, bus.ibus_req_out}, 32'h0);
    check("rst_addr",  bus.ibus_addr_out, 32'h0);
    check("rst_valid", {31'b0, inst_valid_out}, 32'h0);
    check("rst_inst",  inst_out, 32'h13);
    check("rst_iaddr", inst_addr_out, 32'h0);
    step(1);
    check("t1_req",    {31'b0, bus.ibus_req_out}, 32'h1);
    check("t1_addr0",  bus.ibus_addr_out, 32'h0);
    check("t1_valid0", {31'b0, inst_valid_out}, 32'h0);
    step(1);
    check("t1_v_a",    {31'b0, inst_valid_out}, 32'h1);
    check("t1_inst0",  inst_out, 32'h0);
    check("t1_iaddr0", inst_addr_out, 32'h0);
    check("t1_addr4",  bus.ibus_addr_out, 32'h4);
    step(1);
    check("t1_iaddr4", inst_addr_out, 32'h4);
    check("t1_inst4",  inst_out, 32'h4);
    step(1);
    check("t1_iaddr8", inst_addr_out, 32'h8);
    check("t1_v_c",    {31'b0, inst_valid_out}, 32'h1);

    // Two wait cycles per request
    ack_delay = 2;
    do_reset();
    step(1);
    check("t2_addr_e1",  bus.ibus_addr_out, 32'h0);
    step(1);
    check("t2_addr_e2",  bus.ibus_addr_out, 32'h0);
    check("t2_valid_e2", {31'b0, inst_valid_out}, 32'h0);
    step(1);
    check("t2_addr_e3",  bus.ibus_addr_out, 32'h0);
    check("t2_inst_e3",  inst_out, 32'h13);
    step(1);
    check("t2_valid_e4", {31'b0, inst_valid_out}, 32'h1);
    check("t2_iaddr_e4", inst_addr_out, 32'h0);
    check("t2_addr_e4",  bus.ibus_addr_out, 32'h4);
    step(1);
    check("t2_valid_e5", {31'b0, inst_valid_out}, 32'h0);
    check("t2_inst_e5",  inst_out, 32'h13);
    check("t2_iaddr_e5", inst_addr_out, 32'h0);
    step(1);
    check("t2_valid_e6", {31'b0, inst_valid_out}, 32'h0);
    check("t2_addr_e6",  bus.ibus_addr_out, 32'h4);
    step(1);
    check("t2_valid_e7", {31'b0, inst_valid_out}, 32'h1);
    check("t2_iaddr_e7", inst_addr_out, 32'h4);
    check("t2_addr_e7",  bus.ibus_addr_out, 32'h8);

    // Hold for three cycles while 0x8 returns
    ack_delay = 0;
    do_reset();
    step(3);
    check("t3_iaddr_pre", inst_addr_out, 32'h4);
    hold_flag_in = 1'b1;
    step(1);
    check("t3_iaddr_h1", inst_addr_out, 32'h4);
    check("t3_req_h1",   {31'b0, bus.ibus_req_out}, 32'h0);
    step(1);
    check("t3_req_h2",   {31'b0, bus.ibus_req_out}, 32'h0);
    step(1);
    check("t3_iaddr_h3", inst_addr_out, 32'h4);
    check("t3_valid_h3", {31'b0, inst_valid_out}, 32'h1);
    hold_flag_in = 1'b0;
    step(1);
    check("t3_iaddr_rel", inst_addr_out, 32'h8);
    check("t3_inst_rel",  inst_out, 32'h8);
    check("t3_req_rel",   {31'b0, bus.ibus_req_out}, 32'h1);
    check("t3_addr_rel",  bus.ibus_addr_out, 32'hC);

    // Jump while 0x10 is outstanding
    ack_delay = 0;
    do_reset();
    step(5);
    check("t4_addr_10", bus.ibus_addr_out, 32'h10);
    ack_delay = 2;
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h103;
    step(1);
    jump_flag_in = 1'b0;
    check("t4_valid_j", {31'b0, inst_valid_out}, 32'h0);
    check("t4_inst_j",  inst_out, 32'h13);
    check("t4_addr_j",  bus.ibus_addr_out, 32'h10);
    check("t4_req_j",   {31'b0, bus.ibus_req_out}, 32'h1);
    step(1);
    check("t4_valid_w", {31'b0, inst_valid_out}, 32'h0);
    step(1);
    check("t4_addr_100", bus.ibus_addr_out, 32'h100);
    check("t4_valid_k",  {31'b0, inst_valid_out}, 32'h0);
    step(2);
    check("t4_valid_w2", {31'b0, inst_valid_out}, 32'h0);
    step(1);
    check("t4_valid_t",  {31'b0, inst_valid_out}, 32'h1);
    check("t4_iaddr_t",  inst_addr_out, 32'h100);
    check("t4_inst_t",   inst_out, 32'h100);

    // Jump and hold together with the skid full
    ack_delay = 0;
    do_reset();
    step(3);
    hold_flag_in = 1'b1;
    step(1);
    check("t5_req_full",   {31'b0, bus.ibus_req_out}, 32'h0);
    check("t5_iaddr_full", inst_addr_out, 32'h4);
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h200;
    step(1);
    jump_flag_in = 1'b0;
    hold_flag_in = 1'b0;
    check("t5_valid_j", {31'b0, inst_valid_out}, 32'h0);
    check("t5_inst_j",  inst_out, 32'h13);
    check("t5_req_j",   {31'b0, bus.ibus_req_out}, 32'h1);
    check("t5_addr_j",  bus.ibus_addr_out, 32'h200);
    step(1);
    check("t5_valid_t", {31'b0, inst_valid_out}, 32'h1);
    check("t5_iaddr_t", inst_addr_out, 32'h200);

    // Reset pulse with ack arriving in the reset cycle
    ack_delay = 2;
    do_reset();
    step(3);
    check("t6_ack_pre", {31'b0, bus.ibus_ack_in}, 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_req",   {31'b0, bus.ibus_req_out}, 32'h0);
    check("t6_addr",  bus.ibus_addr_out, 32'h0);
    check("t6_valid", {31'b0, inst_valid_out}, 32'h0);
    check("t6_inst",  inst_out, 32'h13);
    check("t6_iaddr", inst_addr_out, 32'h0);
    step(1);
    check("t6_req_e1",   {31'b0, bus.ibus_req_out}, 32'h1);
    check("t6_addr_e1",  bus.ibus_addr_out, 32'h0);
    check("t6_valid_e1", {31'b0, inst_valid_out}, 32'h0);
    step(2);
    check("t6_valid_e3", {31'b0, inst_valid_out}, 32'h0);
    step(1);
    check("t6_valid_e4", {31'b0, inst_valid_out}, 32'h1);
    check("t6_iaddr_e4", inst_addr_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
Instruction-fetch stage: the consumer of the pipeline-control jump/hold outputs.
- Owns the PC and issues single-outstanding requests on the instruction bus.
- Presents fetched instructions to decode through a registered IF/ID output.
- Honours jump redirects (squashing in-flight and buffered fetches) and hold stalls (freezing output, buffering one returning instruction).

Parameters:
RESET_ADDR, 32'h0000_0000, PC of the first fetch after reset
NOP_INST, 32'h0000_0013, instruction driven when inst_valid_out=0 (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
jump_flag_in  input  1  redirect request (`JumpEnable = 1)
jump_addr_in  input  32  redirect target (`MemAddressBus)
hold_flag_in  input  1  stall request (`HoldEnable = 1)
ibus_req_out  output  1  fetch request, registered
ibus_addr_out  output  32  fetch address, registered, word aligned
ibus_ack_in  input  1  completion; data valid in the same cycle
ibus_data_in  input  32  fetched instruction
inst_valid_out  output  1  IF/ID entry holds a real instruction
inst_out  output  32  instruction to decode (NOP_INST when invalid)
inst_addr_out  output  32  PC of inst_out

Behaviour:
- Reset (sync, any cycle, mid-transaction included):
  - fetch_pc=RESET_ADDR; ibus_req_out=0; ibus_addr_out=RESET_ADDR.
  - kill=0; skid empty.
  - inst_valid_out=0; inst_out=NOP_INST; inst_addr_out=RESET_ADDR.
  - A pending ack is ignored. The first request asserts the cycle after rst deasserts.
- Bus rules:
  - A transaction completes at an edge with ibus_req_out=1 and ibus_ack_in=1.
  - Request is never withdrawn and its address never changes before completion.
  - At most one outstanding request.
- Issue:
  - Allowed at an edge when no request is outstanding, or one completes at that edge, AND the skid is empty after that edge.
  - Action: ibus_req_out<=1, ibus_addr_out<=fetch_pc, fetch_pc<=fetch_pc+4 (wrap modulo 2^32).
  - Otherwise ibus_req_out<=0 after completion.
  - Zero-wait memory gives 1 instruction/cycle.
- Completion, non-killed:
  - hold=0 and skid empty: the IF/ID register loads {1, data, addr}.
  - Otherwise: load the skid.
  - The skid cannot already be full, because issue is blocked while it is.
- Completion, killed: data discarded; kill<=0.
- IF/ID advance at each edge:
  - hold=1: outputs unchanged.
  - hold=0, skid full: IF/ID<=skid, skid cleared.
  - hold=0, no skid, no completion: inst_valid_out<=0, inst_out<=NOP_INST, inst_addr_out unchanged.
- Jump (priority: rst > jump > hold):
  - Target jump_addr_in with bits[1:0] forced to 0.
  - IF/ID<=bubble, even if hold=1.
  - Skid cleared.
  - Request outstanding and not completing this edge: kill<=1, fetch_pc<=target; the target is issued on the edge the killed request completes.
  - Otherwise the target is issued at this edge: ibus_addr_out<=target, fetch_pc<=target+4.
  - Completion coincident with jump: data discarded.
  - A second jump while kill=1 only updates fetch_pc.

Decomposition:
Shared defines (existing global defines file):
- `MemAddressBus, `InstBus (31:0)
- `JumpEnable/`HoldEnable
- `NopInst (32'h13), `ResetAddr

Local:
- 1-bit state encoding (IDLE/WAIT), expressed as an outstanding flag.

Sub-module: core_fetch_skid
- 1-entry {addr, inst} buffer with load/drain/flush and full flag.
- Also reused for the IF/ID register shape.

Test Plan:
- Reset, ack tied high: req rises the cycle after rst falls at 0x0. Outputs 0x0, 0x4, 0x8 valid on consecutive cycles, with data echoing ibus_addr.
- Ack 2 cycles after each req: ibus_addr_out stable across wait cycles. inst_valid_out is 1 for one cycle per 3, bubbles are NOP 0x13, inst_addr 0x0, 0x4.
- Zero-wait, hold=1 for 3 cycles while 0x8 is acked: output frozen at 0x4, 0x8 lands in skid, and no request for 0xC while the skid is full. Hold released: 0x8 out next cycle, 0xC issued.
- Jump to 0x103 while request 0x10 is outstanding (ack delayed 2 cycles): bubble out, 0x10 data discarded, next request 0x100, first valid output addr 0x100.
- Jump and hold both asserted with skid full: skid flushed, bubble out, request to target issued in the same edge.
- rst pulse during an outstanding request with ack arriving in the reset cycle: all outputs at reset values. The next req address is 0x0, with no stale instruction delivered.
